// File: rtl/rr_grant_ctrl.sv
// -----------------------------------------------------------------------------
// rr_grant_ctrl
//   Round-robin arbiter for 8 requesters sharing one decoded-select bus.
//   Ownership is bounded to MAX_HOLD consecutive cycles. Every release is
//   followed by one dead cycle, so two grants can never overlap on the bus.
//
//   Handshake: req[i] is a level. Requester i owns the bus in every cycle
//   where gnt[i]=1 (equivalently sel_en=1 and sel=i). Dropping req[i] while
//   granted releases the bus at the next edge. A grant is never revoked
//   early except by the hold-time limit, which is flagged by timeout.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   req[7:0] in   request levels, bit i = requester i
//   en       in   arbitration enable; 0 blocks new grants only
//   sel[2:0] out  index of current/last owner (qualify with sel_en)
//   sel_en   out  1 while a grant is active
//   gnt[7:0] out  registered one-hot grant, 0 when no grant is active
//   busy     out  1 in GRANT or RELEASE
//   timeout  out  one-cycle pulse in the RELEASE cycle after a forced release
// -----------------------------------------------------------------------------
module rr_grant_ctrl #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       en,
    output logic [2:0] sel,
    output logic       sel_en,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Counter value seen in the last permitted grant cycle.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic       timeout_q, timeout_d;

    logic [2:0] winner;
    logic       winner_vld;
    logic [2:0] scan_idx;

    // Winner: first set request bit at or after ptr, wrapping 7 -> 0.
    // The 3-bit add provides the wrap for free.
    always_comb begin
        winner     = 3'd0;
        winner_vld = 1'b0;
        scan_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            scan_idx = ptr_q + 3'(i);
            if (!winner_vld && req[scan_idx]) begin
                winner     = scan_idx;
                winner_vld = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= 3'd0;
            ptr_q     <= 3'd0;
            cnt_q     <= 8'd0;
            gnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                // RELEASE arbitrates with the pointer already moved past the
                // previous owner, so the freshly released requester is last.
                if (en && winner_vld) begin
                    state_d = ST_GRANT;
                    sel_d   = winner;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[sel_q]) begin
                    state_d = ST_RELEASE;
                    ptr_d   = sel_q + 3'd1;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d   = ST_RELEASE;
                    ptr_d     = sel_q + 3'd1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode. gnt is registered from the next state so the bus sees a
    // clean flop output rather than a decode of state and sel.
    always_comb begin
        gnt_d = 8'd0;
        if (state_d == ST_GRANT) begin
            gnt_d = 8'd1 << sel_d;
        end
    end

    assign sel     = sel_q;
    assign sel_en  = (state_q == ST_GRANT);
    assign busy    = (state_q != ST_IDLE);
    assign gnt     = gnt_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rr_grant_ctrl
//   Two instances share the same stimulus: MAX_HOLD=4 and MAX_HOLD=1.
//   A behavioural model per instance tracks owner / cycles used / dead gap /
//   rotate pointer and predicts every output after every edge.
// -----------------------------------------------------------------------------
module tb_rr_grant_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       en;

    logic [2:0] sel0, sel1;
    logic       sel_en0, sel_en1;
    logic [7:0] gnt0, gnt1;
    logic       busy0, busy1;
    logic       timeout0, timeout1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    rr_grant_ctrl #(.MAX_HOLD(4)) dut0 (
        .clk(clk), .rst(rst), .req(req), .en(en),
        .sel(sel0), .sel_en(sel_en0), .gnt(gnt0), .busy(busy0), .timeout(timeout0)
    );

    rr_grant_ctrl #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .en(en),
        .sel(sel1), .sel_en(sel_en1), .gnt(gnt1), .busy(busy1), .timeout(timeout1)
    );

    // ---------------- behavioural model ----------------
    int hold_lim[2] = '{4, 1};
    int m_owner[2];  // -1 when nobody owns the bus
    int m_used[2];   // grant cycles consumed by current owner
    int m_ptr[2];
    int m_sel[2];
    bit m_gap[2];    // in the dead cycle after a release
    bit m_to[2];     // that dead cycle follows a forced release

    function automatic int pick(int ptr, logic [7:0] r);
        for (int k = 0; k < 8; k++) begin
            if (r[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_owner[u] = -1; m_used[u] = 0; m_ptr[u] = 0;
            m_sel[u] = 0; m_gap[u] = 1'b0; m_to[u] = 1'b0;
        end
    endtask

    task automatic model_edge(logic [7:0] r, logic e);
        for (int u = 0; u < 2; u++) begin
            if (m_owner[u] >= 0) begin
                if (!r[m_owner[u]] || m_used[u] == hold_lim[u]) begin
                    m_to[u]    = r[m_owner[u]];
                    m_ptr[u]   = (m_owner[u] + 1) % 8;
                    m_owner[u] = -1;
                    m_gap[u]   = 1'b1;
                end else begin
                    m_used[u]++;
                end
            end else begin
                m_gap[u] = 1'b0;
                m_to[u]  = 1'b0;
                if (e && r != 8'd0) begin
                    m_owner[u] = pick(m_ptr[u], r);
                    m_sel[u]   = m_owner[u];
                    m_used[u]  = 1;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %02h expected %02h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_gnt(int u);
        return (m_owner[u] >= 0) ? (8'd1 << m_owner[u]) : 8'd0;
    endfunction

    task automatic compare_all();
        chk("gnt0",     gnt0,            exp_gnt(0));
        chk("sel0",     {5'd0, sel0},    8'(m_sel[0]));
        chk("sel_en0",  {7'd0, sel_en0}, {7'd0, m_owner[0] >= 0});
        chk("busy0",    {7'd0, busy0},   {7'd0, (m_owner[0] >= 0) || m_gap[0]});
        chk("timeout0", {7'd0, timeout0},{7'd0, m_gap[0] && m_to[0]});
        chk("gnt1",     gnt1,            exp_gnt(1));
        chk("sel1",     {5'd0, sel1},    8'(m_sel[1]));
        chk("sel_en1",  {7'd0, sel_en1}, {7'd0, m_owner[1] >= 0});
        chk("busy1",    {7'd0, busy1},   {7'd0, (m_owner[1] >= 0) || m_gap[1]});
        chk("timeout1", {7'd0, timeout1},{7'd0, m_gap[1] && m_to[1]});
    endtask

    // ---------------- driver tasks ----------------
    // Called 1 time unit after an edge: drive, take the edge, predict, compare.
    task automatic step(logic [7:0] r, logic e);
        req = r;
        en  = e;
        @(posedge clk);
        model_edge(r, e);
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("async_rst_gnt0",  gnt0,             8'h00);
        chk("async_rst_busy0", {7'd0, busy0},    8'h00);
        chk("async_rst_selen0",{7'd0, sel_en0},  8'h00);
        #2 rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        req = 8'h00;
        en  = 1'b0;
        model_reset();
        #12;
        compare_all();
        chk("reset_gnt0", gnt0, 8'h00);
        chk("reset_sel0", {5'd0, sel0}, 8'h00);
        rst = 1'b0;

        // Single request held 3 cycles then dropped.
        step(8'h08, 1'b1);
        chk("single_gnt0", gnt0, 8'h08);
        chk("single_sel0", {5'd0, sel0}, 8'h03);
        step(8'h08, 1'b1);
        step(8'h08, 1'b1);
        chk("single_gnt0_c3", gnt0, 8'h08);
        step(8'h00, 1'b1);
        chk("single_rel_gnt0", gnt0, 8'h00);
        chk("single_rel_busy0", {7'd0, busy0}, 8'h01);
        chk("single_rel_to0", {7'd0, timeout0}, 8'h00);
        step(8'h00, 1'b1);
        chk("single_idle_busy0", {7'd0, busy0}, 8'h00);

        // Timeout with a sole requester held forever.
        for (int i = 0; i < 12; i++) begin
            step(8'h01, 1'b1);
            if (i == 3) chk("to_last_gnt0", gnt0, 8'h01);
            if (i == 4) begin
                chk("to_pulse0", {7'd0, timeout0}, 8'h01);
                chk("to_dead_gnt0", gnt0, 8'h00);
            end
            if (i == 5) chk("to_regrant_gnt0", gnt0, 8'h01);
        end

        // Rotation with all requesting.
        for (int i = 0; i < 45; i++) step(8'hFF, 1'b1);

        // Wrap and priority: owner 6 released, then 7 then 0.
        for (int i = 0; i < 3; i++) step(8'h00, 1'b1);
        step(8'h40, 1'b1);
        step(8'h40, 1'b1);
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        step(8'h81, 1'b1);
        chk("wrap_sel0", {5'd0, sel0}, 8'h07);
        chk("wrap_gnt0", gnt0, 8'h80);
        for (int k = 0; k < 5; k++) begin
            step(8'h81, 1'b1);
            if (k == 4) chk("wrap_next_gnt0", gnt0, 8'h01);
        end

        // Enable gating.
        for (int i = 0; i < 3; i++) step(8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(8'h20, 1'b0);
            chk("en_off_busy0", {7'd0, busy0}, 8'h00);
        end
        step(8'h20, 1'b1);
        chk("en_on_gnt0", gnt0, 8'h20);
        step(8'h20, 1'b0);
        chk("en_drop_gnt0", gnt0, 8'h20);
        step(8'h00, 1'b0);
        step(8'h20, 1'b0);
        chk("en_drop_idle_busy0", {7'd0, busy0}, 8'h00);
        chk("en_drop_idle_gnt0", gnt0, 8'h00);

        // Asynchronous reset mid-grant.
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        step(8'h10, 1'b1);
        step(8'h10, 1'b1);
        async_reset();
        step(8'h10, 1'b1);
        chk("post_rst_gnt0", gnt0, 8'h10);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] r;
            logic       e;
            case ($urandom_range(0, 3))
                0: r = 8'($urandom_range(0, 255));
                1: r = 8'd1 << $urandom_range(0, 7);
                2: r = req;
                default: r = req ^ (8'd1 << $urandom_range(0, 7));
            endcase
            e = ($urandom_range(0, 9) != 0);
            step(r, e);
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
